// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: EX-stage <-> MDU bundle.
//   master (pipeline side): drives the op, operands, multiplier products and
//                           MFHI/MFLO requests; reads hi/lo/busy/stall.
//   slave  (MDU side)     : the reverse.
interface hilo_mdu_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [63:0] mult_res;
  logic [63:0] multu_res;
  logic        rd_hi_req;
  logic        rd_lo_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output op_valid, op, rs_data, rt_data, mult_res, multu_res, rd_hi_req, rd_lo_req,
    input  hi, lo, busy, stall
  );
  modport slave (
    input  op_valid, op, rs_data, rt_data, mult_res, multu_res, rd_hi_req, rd_lo_req,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO register owner for the EX stage.
//   MULT/MULTU  : capture the external multiplier product in one cycle.
//   DIV/DIVU    : 32-step restoring divider on operand magnitudes, sign fixup
//                 applied on the final step.
//   MTHI/MTLO   : direct register writes.
// Ports:
//   clk, rst_n  : clock (rising edge), async active-low reset
//   bus (slave) : op/operands/products/read requests in; hi, lo, busy, stall out
module hilo_mdu #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  hilo_mdu_if.slave  bus
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t        state;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [32:0]   rem_q;
  logic [31:0]   quo_q, dvsr_q;
  logic [CW-1:0] cnt_q;
  logic          qneg_q, rneg_q;

  logic          is_mdu, accept, sgn;
  logic [31:0]   rs_mag, rt_mag;
  logic [32:0]   rem_sh, rem_n;
  logic [33:0]   diff;
  logic [31:0]   quo_n;

  // Reserved op 111 and NONE are both "not an MDU op".
  assign is_mdu = bus.op_valid && (bus.op != 3'b000) && (bus.op != 3'b111);
  assign accept = is_mdu && (state == S_IDLE);
  assign sgn    = (bus.op == OP_DIV);
  assign rs_mag = (sgn && bus.rs_data[31]) ? 32'(-bus.rs_data) : bus.rs_data;
  assign rt_mag = (sgn && bus.rt_data[31]) ? 32'(-bus.rt_data) : bus.rt_data;

  // One restoring step: shift {rem,quo}, trial subtract, keep if non-negative.
  always_comb begin
    rem_sh = {rem_q[31:0], quo_q[31]};
    diff   = {1'b0, rem_sh} - {2'b00, dvsr_q};
    quo_n  = {quo_q[30:0], ~diff[33]};
    rem_n  = diff[33] ? rem_sh : diff[32:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          case (bus.op)
            OP_MULT:  {hi_q, lo_q} <= bus.mult_res;
            OP_MULTU: {hi_q, lo_q} <= bus.multu_res;
            OP_MTHI:  hi_q <= bus.rs_data;
            OP_MTLO:  lo_q <= bus.rs_data;
            OP_DIV, OP_DIVU: begin
              if (bus.rt_data == '0) begin
                // Divide by zero completes immediately with a fixed pattern.
                lo_q <= 32'hFFFF_FFFF;
                hi_q <= bus.rs_data;
              end else begin
                quo_q  <= rs_mag;
                dvsr_q <= rt_mag;
                rem_q  <= '0;
                qneg_q <= sgn && (bus.rs_data[31] ^ bus.rt_data[31]);
                rneg_q <= sgn && bus.rs_data[31];
                cnt_q  <= '0;
                state  <= S_DIV;
                busy_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        S_DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // 0x80000000 / -1 falls out naturally: magnitude quotient
            // 0x80000000 is left un-negated because both signs are set.
            lo_q   <= qneg_q ? 32'(-quo_n) : quo_n;
            hi_q   <= rneg_q ? 32'(-rem_n[31:0]) : rem_n[31:0];
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.stall = busy_q && (bus.rd_hi_req || bus.rd_lo_req || is_mdu);
endmodule
